mem_store_buffer: RTL

// - Posted-write buffer directly downstream of the store formatter.
// - Accepts byte-lane-formatted stores (byte enables + lane-aligned data + address) from the memory stage.
// - Queues them in a small FIFO and drains them in order to the data bus with a valid/ready handshake,
//   so a slow memory does not stall the pipeline.
// - Flags a load hazard when a load targets a word that still has a pending store.
//

---
 rtl/mem_store_buffer_pkg.sv | 16 +
 rtl/mem_store_buffer_cam.sv | 27 ++
 rtl/mem_store_buffer.sv | 113 +++++++++++
 3 files changed

// File: rtl/mem_store_buffer_pkg.sv
// Shared definitions for the posted-write store buffer, store formatter and load unit.
package mem_store_buffer_pkg;

  localparam int DATA_W   = 32;
  localparam int BE_W     = 4;
  localparam int WORD_LSB = 2;   // byte-offset bits dropped for word-aligned entries

  localparam logic [BE_W-1:0] BE_NONE = 4'b0000;
  localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

  // True when the byte enables touch at least one lane of the bus word.
  function automatic logic has_lanes(input logic [BE_W-1:0] we);
    return (we & BE_WORD) != BE_NONE;
  endfunction

endpackage

// File: rtl/mem_store_buffer_cam.sv
// Word-address comparator across all buffer entries, masked by entry valid bits.
module mem_store_buffer_cam
  import mem_store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = DATA_W - WORD_LSB
) (
  input  logic [DEPTH-1:0][TAG_W-1:0] i_tags,
  input  logic [DEPTH-1:0]            i_vld,
  input  logic                        i_check_en,
  input  logic [TAG_W-1:0]            i_check_tag,
  output logic                        o_hit
);

  logic [DEPTH-1:0] w_match;

  // Per-entry match, then OR-reduce; a disabled check never reports a hit.
  always_comb begin
    w_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_match[i] = i_vld[i] && (i_tags[i] == i_check_tag);
    end
  end

  assign o_hit = i_check_en & (|w_match);

endmodule

// File: rtl/mem_store_buffer.sv
// Posted-write FIFO between the store formatter and the data bus; flags loads that
// hit a word with a pending store.
module mem_store_buffer
  import mem_store_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       st_valid,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [BE_W-1:0]            st_we,
  input  logic [DATA_W-1:0]          st_wdata,
  output logic                       st_ready,
  input  logic                       ld_check_en,
  input  logic [ADDR_W-1:0]          ld_check_addr,
  output logic                       ld_hazard,
  output logic                       mem_valid,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [BE_W-1:0]            mem_we,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic                       mem_ready,
  output logic                       buf_empty,
  output logic [$clog2(DEPTH+1)-1:0] buf_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int TAG_W = ADDR_W - WORD_LSB;

  logic [DEPTH-1:0][TAG_W-1:0]  r_tag;
  logic [DEPTH-1:0][BE_W-1:0]   r_we;
  logic [DEPTH-1:0][DATA_W-1:0] r_wdata;
  logic [DEPTH-1:0]             r_vld;
  logic [PTR_W-1:0]             r_wr_ptr;
  logic [PTR_W-1:0]             r_rd_ptr;
  logic [CNT_W-1:0]             r_count;

  logic w_push;
  logic w_pop;
  logic w_unused_lsbs;

  // Full/empty come from the registered count only, so no same-cycle bypass when full.
  assign st_ready  = (r_count != CNT_W'(DEPTH));
  assign mem_valid = (r_count != '0);
  assign buf_empty = ~mem_valid;
  assign buf_count = r_count;

  // Stores with no byte lanes enabled are dropped without creating an entry.
  assign w_push = st_valid & st_ready & has_lanes(st_we);
  assign w_pop  = mem_valid & mem_ready;

  // Byte-offset bits never participate in storage or comparison.
  assign w_unused_lsbs = ^{st_addr[WORD_LSB-1:0], ld_check_addr[WORD_LSB-1:0]};

  // Control state: pointers, occupancy and entry valid bits; reset discards everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_vld    <= '0;
    end else begin
      if (w_pop) begin
        r_rd_ptr        <= r_rd_ptr + PTR_W'(1);
        r_vld[r_rd_ptr] <= 1'b0;
      end
      if (w_push) begin
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
        r_vld[r_wr_ptr] <= 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload storage; validity is tracked separately so no reset is needed here.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tag[r_wr_ptr]   <= st_addr[ADDR_W-1:WORD_LSB];
      r_we[r_wr_ptr]    <= st_we;
      r_wdata[r_wr_ptr] <= st_wdata;
    end
  end

  // Head entry onto the bus, zeroed while the buffer is empty.
  always_comb begin
    mem_addr  = '0;
    mem_we    = BE_NONE;
    mem_wdata = '0;
    if (mem_valid) begin
      mem_addr  = {r_tag[r_rd_ptr], {WORD_LSB{1'b0}}};
      mem_we    = r_we[r_rd_ptr];
      mem_wdata = r_wdata[r_rd_ptr];
    end
  end

  mem_store_buffer_cam #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_cam (
    .i_tags      (r_tag),
    .i_vld       (r_vld),
    .i_check_en  (ld_check_en),
    .i_check_tag (ld_check_addr[ADDR_W-1:WORD_LSB]),
    .o_hit       (ld_hazard)
  );

endmodule
